mem_port_arbiter: RTL

//  Shares the single backing-memory port between the icache and dcache refill/

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the icache and dcache miss paths.
// One transaction is outstanding at a time. Grants favour the dcache, but the
// icache is forced through after STARVE_LIMIT consecutive contested dcache wins.
//
// Handshake rule (all request channels): a transfer happens on a cycle where
// valid and ready are both high at the rising clock edge. The requester keeps
// valid and its fields stable until then. Dropping valid before ready simply
// withdraws the request. Response channels are one-cycle pulses with no
// back-pressure.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ic_req_valid,
  output logic            ic_req_ready,
  input  logic [AW-1:0]   ic_req_addr,
  output logic            ic_resp_valid,
  output logic [DW-1:0]   ic_resp_data,
  input  logic            dc_req_valid,
  output logic            dc_req_ready,
  input  logic [AW-1:0]   dc_req_addr,
  input  logic            dc_req_we,
  input  logic [DW-1:0]   dc_req_wdata,
  input  logic [DW/8-1:0] dc_req_wmask,
  output logic            dc_resp_valid,
  output logic [DW-1:0]   dc_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_we,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_data,
  output logic [1:0]      dbg_state
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          owner_ic;
  logic          grant_ic;
  logic          ic_fire;
  logic          dc_fire;

  // icache wins when it is alone or when the dcache has starved it long enough
  assign grant_ic  = ic_req_valid && (!dc_req_valid || (starve_cnt == LIMIT));
  assign ic_fire   = ic_req_valid && ic_req_ready;
  assign dc_fire   = dc_req_valid && dc_req_ready;
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (ic_fire || dc_fire) state_nxt = S_ISSUE;
      S_ISSUE: if (mem_req_ready)      state_nxt = S_WAIT;
      S_WAIT:  if (mem_resp_valid)     state_nxt = S_RESP;
      S_RESP:                          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // Outputs: grants only in IDLE and never while reset is asserted
  always_comb begin
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    ic_resp_valid = 1'b0;
    dc_resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        ic_req_ready = reset && grant_ic;
        dc_req_ready = reset && dc_req_valid && !grant_ic;
      end
      S_ISSUE: mem_req_valid = 1'b1;
      S_RESP: begin
        ic_resp_valid = owner_ic;
        dc_resp_valid = !owner_ic;
      end
      default: ;
    endcase
  end

  // Request latching, starvation counting and response capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt    <= '0;
      owner_ic      <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      ic_resp_data  <= '0;
      dc_resp_data  <= '0;
    end else begin
      if (ic_fire) begin
        owner_ic      <= 1'b1;
        mem_req_addr  <= ic_req_addr;
        mem_req_we    <= 1'b0;
        mem_req_wdata <= '0;
        mem_req_wmask <= '0;
        starve_cnt    <= '0;
      end else if (dc_fire) begin
        owner_ic      <= 1'b0;
        mem_req_addr  <= dc_req_addr;
        mem_req_we    <= dc_req_we;
        mem_req_wdata <= dc_req_wdata;
        mem_req_wmask <= dc_req_wmask;
        // Only a contested win counts toward icache starvation
        if (ic_req_valid && (starve_cnt != LIMIT)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
      if ((state == S_WAIT) && mem_resp_valid) begin
        if (owner_ic) begin
          ic_resp_data <= mem_resp_data;
        end else begin
          dc_resp_data <= mem_resp_data;
        end
      end
    end
  end

endmodule
